// File: rtl/div_pkg.sv
// Shared types and constants for the signed division path.
package div_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Extremes of the default-width signed range; the top derives the same
  // values for whatever WIDTH it is built with.
  localparam logic [WIDTH-1:0] DIV_MIN = 8'h80;
  localparam logic [WIDTH-1:0] DIV_MAX = 8'h7F;

endpackage

// File: rtl/cond_neg.sv
// Conditional two's-complement negation, result truncated to WIDTH bits.
module cond_neg #(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/div_sign_fix.sv
// Signed fix-up stage behind the unsigned restoring divider: latches operand
// signs at start, corrects quotient/remainder signs and holds the result.
module div_sign_fix
  import div_pkg::*;
#(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inbus1,
  input  logic [WIDTH-1:0] inbus2,
  input  logic [WIDTH-1:0] cat_u,
  input  logic [WIDTH-1:0] rest_u,
  input  logic             div_done,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] cat,
  output logic [WIDTH-1:0] rest,
  output logic             div_zero,
  output logic             ovf,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};

  // Handshake: the result is offered with out_valid and held unchanged until
  // the edge where out_valid && out_ready are both high; out_valid then drops.
  state_t           state_q, state_d;
  logic             s1_q, s1_d, s2_q, s2_d, z_q, z_d, o_q, o_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] cat_q, cat_d, rest_q, rest_d;
  logic             div_zero_q, div_zero_d, ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] cat_fix, rest_fix;

  cond_neg #(.WIDTH(WIDTH)) u_neg_cat (
    .x   (cat_u),
    .neg (s1_q ^ s2_q),
    .y   (cat_fix)
  );

  cond_neg #(.WIDTH(WIDTH)) u_neg_rest (
    .x   (rest_u),
    .neg (s1_q),
    .y   (rest_fix)
  );

  always_comb begin
    state_d     = state_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    z_d         = z_q;
    o_d         = o_q;
    dividend_d  = dividend_q;
    out_valid_d = out_valid_q;
    cat_d       = cat_q;
    rest_d      = rest_q;
    div_zero_d  = div_zero_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          s1_d       = inbus1[WIDTH-1];
          s2_d       = inbus2[WIDTH-1];
          z_d        = (inbus2 == '0);
          o_d        = (inbus1 == MIN_V) && (inbus2 == '1);
          dividend_d = inbus1;
          state_d    = BLANK;
        end
      end
      // The divider's done flag may still be high from the last operation.
      BLANK: state_d = WAIT;
      WAIT: begin
        if (div_done) begin
          out_valid_d = 1'b1;
          state_d     = HOLD;
          cat_d       = cat_fix;
          rest_d      = rest_fix;
          div_zero_d  = 1'b0;
          ovf_d       = 1'b0;
          if (z_q) begin
            cat_d      = '0;
            rest_d     = dividend_q;
            div_zero_d = 1'b1;
          end else if (o_q) begin
            cat_d  = MAX_V;
            rest_d = '0;
            ovf_d  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      z_q         <= 1'b0;
      o_q         <= 1'b0;
      dividend_q  <= '0;
      out_valid_q <= 1'b0;
      cat_q       <= '0;
      rest_q      <= '0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      z_q         <= z_d;
      o_q         <= o_d;
      dividend_q  <= dividend_d;
      out_valid_q <= out_valid_d;
      cat_q       <= cat_d;
      rest_q      <= rest_d;
      div_zero_q  <= div_zero_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign cat       = cat_q;
  assign rest      = rest_q;
  assign div_zero  = div_zero_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_div_sign_fix.sv
// Bench for div_sign_fix: plays the unsigned divider and checks signed results
// against plain integer division.
module tb_div_sign_fix;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] inbus1 = '0, inbus2 = '0, cat_u = '0, rest_u = '0;
  logic       div_done = 1'b0, out_ready = 1'b0;
  logic       out_valid, div_zero, ovf, busy;
  logic [7:0] cat, rest;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_sign_fix #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .inbus1(inbus1), .inbus2(inbus2),
    .cat_u(cat_u), .rest_u(rest_u), .div_done(div_done), .out_ready(out_ready),
    .out_valid(out_valid), .cat(cat), .rest(rest), .div_zero(div_zero),
    .ovf(ovf), .busy(busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Signed reference: SV integer division truncates toward zero and the
  // remainder carries the dividend's sign.
  task automatic model(input int a, input int b, output logic [7:0] c,
                       output logic [7:0] r, output logic z, output logic o);
    int q, m;
    z = 1'b0; o = 1'b0;
    if (b == 0) begin
      c = 8'h00; r = 8'(a); z = 1'b1;
    end else if (a == -128 && b == -1) begin
      c = 8'h7F; r = 8'h00; o = 1'b1;
    end else begin
      q = a / b; m = a % b;
      c = 8'(q); r = 8'(m);
    end
  endtask

  // What an unsigned restoring divider reports for |a| / |b|.
  task automatic divider(input int a, input int b, output logic [7:0] cu, output logic [7:0] ru);
    int ua, ub;
    ua = (a < 0) ? -a : a;
    ub = (b < 0) ? -b : b;
    if (ub == 0) begin
      cu = 8'hFF; ru = 8'(ua);
    end else begin
      cu = 8'(ua / ub); ru = 8'(ua % ub);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_valid"}, {7'b0, out_valid}, 8'h00);
    chk({tag, "_busy"},  {7'b0, busy}, 8'h00);
    chk({tag, "_cat"},   cat, 8'h00);
    chk({tag, "_rest"},  rest, 8'h00);
    chk({tag, "_dz"},    {7'b0, div_zero}, 8'h00);
    chk({tag, "_ovf"},   {7'b0, ovf}, 8'h00);
  endtask

  // One full operation: start, BLANK (optionally with a stale done), done_dly
  // idle WAIT cycles, result, hold_dly cycles of backpressure, handshake.
  task automatic run_op(input int a, input int b, input int done_dly,
                        input int hold_dly, input bit stale);
    logic [7:0] ec, er, cu, ru;
    logic       ez, eo;
    model(a, b, ec, er, ez, eo);
    divider(a, b, cu, ru);
    start = 1'b1; inbus1 = 8'(a); inbus2 = 8'(b);
    tick();
    start = 1'b0;
    chk("busy_after_start", {7'b0, busy}, 8'h01);
    chk("blank_no_valid", {7'b0, out_valid}, 8'h00);
    div_done = stale;
    cat_u = 8'($urandom); rest_u = 8'($urandom);
    tick();
    chk("wait_no_valid", {7'b0, out_valid}, 8'h00);
    for (int i = 0; i < done_dly; i++) begin
      div_done = 1'b0;
      tick();
      chk("wait_no_valid", {7'b0, out_valid}, 8'h00);
    end
    div_done = 1'b1; cat_u = cu; rest_u = ru;
    tick();
    div_done = 1'b0;
    for (int i = 0; i <= hold_dly; i++) begin
      chk("res_valid", {7'b0, out_valid}, 8'h01);
      chk("res_cat", cat, ec);
      chk("res_rest", rest, er);
      chk("res_dz", {7'b0, div_zero}, {7'b0, ez});
      chk("res_ovf", {7'b0, ovf}, {7'b0, eo});
      chk("res_busy", {7'b0, busy}, 8'h01);
      if (i < hold_dly) begin
        start = (i == 1); inbus1 = 8'($urandom); inbus2 = 8'($urandom);
        tick();
        start = 1'b0;
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_valid_drop", {7'b0, out_valid}, 8'h00);
    chk("hs_idle", {7'b0, busy}, 8'h00);
    chk("hs_cat_held", cat, ec);
  endtask

  initial begin
    int a, b;
    // Reset state
    rst = 1'b1;
    tick(); tick();
    check_idle_zero("reset");
    rst = 1'b0;
    tick();
    check_idle_zero("post_reset");

    // Directed cases
    run_op(-49, -3, 2, 0, 1'b0);
    run_op(49, -3, 0, 0, 1'b0);
    run_op(59, 4, 1, 0, 1'b0);
    run_op(-128, -1, 3, 0, 1'b0);
    run_op(5, 0, 4, 0, 1'b0);
    run_op(-7, 2, 2, 5, 1'b0);   // backpressure plus ignored second start
    run_op(100, 7, 3, 0, 1'b1);  // stale done in BLANK
    run_op(-128, 1, 0, 0, 1'b0);
    run_op(-5, 0, 1, 1, 1'b1);

    // Reset in WAIT with done high: reset wins
    start = 1'b1; inbus1 = 8'd59; inbus2 = 8'd4;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1; div_done = 1'b1; cat_u = 8'd14; rest_u = 8'd3;
    tick();
    rst = 1'b0; div_done = 1'b0;
    check_idle_zero("rst_in_wait");
    tick();
    check_idle_zero("rst_in_wait_next");
    run_op(59, 4, 0, 0, 1'b0);

    // start together with rst is dropped
    start = 1'b1; rst = 1'b1; inbus1 = 8'd9; inbus2 = 8'd2;
    tick();
    start = 1'b0; rst = 1'b0;
    chk("start_rst_dropped", {7'b0, busy}, 8'h00);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(0, 255)) - 128;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = -1;
        default: b = int'($urandom_range(0, 255)) - 128;
      endcase
      if ($urandom_range(0, 7) == 0) a = -128;
      run_op(a, b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sign_fix.md
# div_sign_fix

Signed-result stage placed directly downstream of `restoring_div` in the 8-bit signed division path. It captures the operand signs and special cases when a division starts, then waits for the unsigned divider to finish. It then applies two's-complement correction to quotient and remainder, flags divide-by-zero and overflow, and holds the signed result behind a valid/ready handshake. It replaces the sign fix-up previously done ad hoc around the divider and makes the signed divider usable by downstream logic.

## Interface
- `WIDTH`, 8: operand/result width in bits.
- `clk`  in  1: clock; all state changes on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: same pulse driven to `restoring_div`; accepted only when `busy`=0.
- `inbus1`  in  WIDTH: raw signed dividend, sampled with `start`.
- `inbus2`  in  WIDTH: raw signed divisor, sampled with `start`.
- `cat_u`  in  WIDTH: unsigned quotient magnitude from `restoring_div`.
- `rest_u`  in  WIDTH: unsigned remainder magnitude from `restoring_div`.
- `div_done`  in  1: `restoring_div` done flag.
- `out_ready`  in  1: consumer accepts the result.
- `out_valid`  out  1: signed result valid.
- `cat`  out  WIDTH: signed quotient.
- `rest`  out  WIDTH: signed remainder.
- `div_zero`  out  1: divisor was 0; qualified by `out_valid`.
- `ovf`  out  1: dividend = -2^(WIDTH-1) and divisor = -1; qualified by `out_valid`.
- `busy`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, BLANK, WAIT, HOLD.
- IDLE, `start`=1: latch `s1`=inbus1[MSB], `s2`=inbus2[MSB], `z`=(inbus2==0), `o`=(inbus1==MIN && inbus2==-1). Transition to BLANK.
- BLANK: lasts exactly one cycle. `div_done` is ignored here because the divider's flag can still be high from the previous operation. Transition to WAIT.
- WAIT, `div_done`=1: register the results, set `out_valid`=1, and go to HOLD. Results are:
  - `cat` = (s1^s2) ? -cat_u : cat_u
  - `rest` = s1 ? -rest_u : rest_u
  - Negation is `~x+1`, truncated to WIDTH bits.
- Overrides, applied in priority order:
  - `z`: `cat`=0, `rest`=latched inbus1, `div_zero`=1, `ovf`=0.
  - `o`: `cat`=MAX (8'h7F), `rest`=0, `ovf`=1.
- The block always waits for `div_done`, including in the zero case, so it stays in lockstep with the divider.
- HOLD: outputs stable. On `out_valid && out_ready`, clear `out_valid` and go to IDLE.
- `start` outside IDLE is ignored; the upstream issuer must gate on `busy`.
- Remainder sign follows the dividend; quotient truncates toward zero.

## Timing
- Reset values: `out_valid`=0, `busy`=0, `cat`=0, `rest`=0, `div_zero`=0, `ovf`=0; state IDLE; latched signs and flags 0.
- `rst` mid-operation: return to IDLE next edge and drop any pending result. The upstream must also reset `restoring_div`.
- `busy` rises the cycle after `start` is accepted.
- Latency: if `div_done` is sampled high at WAIT edge N, `out_valid` and the results are visible after edge N (one-cycle registration).
- Handshake completes at the edge where both `out_valid` and `out_ready` are high.
- `out_ready` held high in HOLD gives exactly one valid cycle.
- Earliest next `start` is accepted one cycle after the handshake edge, once IDLE is reached.
- `div_done` high in BLANK and WAIT simultaneously with `rst`: reset wins.
- `start` and `rst` in the same cycle: reset wins; the start is dropped.

## Structure
- Package `div_pkg` holds:
  - `WIDTH` default
  - state enum {IDLE, BLANK, WAIT, HOLD}
  - constants `DIV_MIN`=8'h80 and `DIV_MAX`=8'h7F
- Sub-module `cond_neg` (WIDTH param; inputs `x`, `neg`; output `neg ? ~x+1 : x`), instantiated twice: once for the quotient, once for the remainder.

## Test plan
- -49 / -3, divider returns `cat_u`=16, `rest_u`=1 → `cat`=16, `rest`=-1, flags 0.
- 49 / -3 → `cat`=-16, `rest`=1.
- 59 / 4 → `cat`=14, `rest`=3.
- Special cases:
  - -128 / -1 → `ovf`=1, `cat`=127, `rest`=0.
  - 5 / 0 → `div_zero`=1, `cat`=0, `rest`=5; `out_valid` appears only after `div_done`.
- Backpressure and stale done:
  - Hold `out_ready`=0 for 5 cycles → `out_valid` and `cat`/`rest` stay stable, and a second `start` is ignored.
  - Leave `div_done` high in BLANK from the prior op → no premature `out_valid`.
- Assert `rst` in WAIT → all outputs 0 next cycle; a following 59/4 completes correctly.
